// File: rtl/cfg_pkg.sv
// Shared helpers and frame-state encoding for the configuration loader.
package cfg_pkg;

   localparam int PAR_MAX = 4096;

   localparam logic [1:0] CFG_EMPTY   = 2'd0;
   localparam logic [1:0] CFG_LOADING = 2'd1;
   localparam logic [1:0] CFG_FULL    = 2'd2;
   localparam logic [1:0] CFG_OVER    = 2'd3;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Returns the bit that makes the vector's total parity even.
   function automatic logic even_parity(input logic [PAR_MAX-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/cfg_shadow_chain.sv
// LANES-wide shadow shift register with saturating beat counter
// and a parallel load path used for readback.
module cfg_shadow_chain
   import cfg_pkg::*;
#(
   parameter int LANES = 1,
   parameter int BEATS = 201,
   parameter int CW    = 8,
   localparam int SH   = BEATS * LANES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic             clr,
   input  logic             load,
   input  logic [SH-1:0]    load_frame,
   input  logic [LANES-1:0] shift_in,
   output logic [LANES-1:0] shift_out,
   output logic [SH-1:0]    shadow,
   output logic [CW-1:0]    beat_count
);

   localparam logic [CW-1:0] FULL_C = CW'(BEATS);
   localparam logic [CW-1:0] OVER_C = CW'(BEATS + 1);

   logic [SH-1:0] shifted;

   if (SH > LANES) begin : g_multi
      assign shifted = {shadow[SH-LANES-1:0], shift_in};
   end else begin : g_single
      assign shifted = shift_in;
   end

   assign shift_out = shadow[SH-1 -: LANES];

   // clr wins over load, load over shift: a beat presented with either is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow     <= '0;
         beat_count <= '0;
      end else if (clr) begin
         beat_count <= '0;
      end else if (load) begin
         shadow     <= load_frame;
         beat_count <= FULL_C;
      end else if (cen) begin
         shadow <= shifted;
         if (beat_count != OVER_C)
            beat_count <= beat_count + 1'b1;
      end
   end

endmodule

// File: rtl/cb_config_loader.sv
// Configuration frame loader: shadow chain, length/parity commit check
// and atomic update of the active configuration bus.
module cb_config_loader
   import cfg_pkg::*;
#(
   parameter int CONF_WIDTH = 200,
   parameter int LANES      = 1,
   parameter int PARITY     = 1,
   localparam int FRAME_BITS = CONF_WIDTH + PARITY,
   localparam int BEATS      = ceil_div(FRAME_BITS, LANES),
   localparam int SH         = BEATS * LANES,
   localparam int CW         = clog2(BEATS + 2)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cen,
   input  logic [LANES-1:0]      shift_in,
   output logic [LANES-1:0]      shift_out,
   input  logic                  set_in,
   input  logic                  readback,
   output logic [CONF_WIDTH-1:0] conf_out,
   output logic                  conf_valid,
   output logic                  frame_err,
   output logic [CW-1:0]         beat_count
);

   localparam logic [SH-1:0] FRAME_MASK = ~({SH{1'b1}} << FRAME_BITS);
   localparam logic [CW-1:0] FULL_C     = CW'(BEATS);
   localparam logic [CW-1:0] OVER_C     = CW'(BEATS + 1);

   logic [SH-1:0] shadow;
   logic [SH-1:0] load_frame;
   logic [1:0]    state;
   logic          rb_par;
   logic          par_ok;
   logic          frame_ok;

   cfg_shadow_chain #(
      .LANES (LANES),
      .BEATS (BEATS),
      .CW    (CW)
   ) u_chain (
      .clk        (clk),
      .rst        (rst),
      .cen        (cen),
      .clr        (set_in),
      .load       (readback),
      .load_frame (load_frame),
      .shift_in   (shift_in),
      .shift_out  (shift_out),
      .shadow     (shadow),
      .beat_count (beat_count)
   );

   always_comb begin
      state = CFG_LOADING;
      unique case (1'b1)
         (beat_count == '0):     state = CFG_EMPTY;
         (beat_count == FULL_C): state = CFG_FULL;
         (beat_count == OVER_C): state = CFG_OVER;
         default:                state = CFG_LOADING;
      endcase
   end

   assign rb_par     = (PARITY != 0) ? even_parity(PAR_MAX'(conf_out)) : 1'b0;
   assign load_frame = SH'({rb_par, conf_out});

   // Pad bits above the frame are masked out of the parity sum.
   assign par_ok   = (PARITY == 0) || !even_parity(PAR_MAX'(shadow & FRAME_MASK));
   assign frame_ok = (state == CFG_FULL) && par_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         conf_out   <= '0;
         conf_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else if (set_in) begin
         if (frame_ok) begin
            conf_out   <= shadow[CONF_WIDTH-1:0];
            conf_valid <= 1'b1;
            frame_err  <= 1'b0;
         end else begin
            frame_err  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cb_config_loader.sv
// Scoreboard bench: two loader instances (10/4/1 and 200/8/1) against a beat-level model.
module tb_cb_config_loader;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       a_cen, a_set, a_rb;
   logic [3:0] a_in, a_so;
   logic [9:0] a_conf;
   logic       a_val, a_err;
   logic [2:0] a_bc;

   logic         b_cen, b_set, b_rb;
   logic [7:0]   b_in, b_so;
   logic [199:0] b_conf;
   logic         b_val, b_err;
   logic [4:0]   b_bc;

   cb_config_loader #(.CONF_WIDTH(10), .LANES(4), .PARITY(1)) dut_a (
      .clk(clk), .rst(rst), .cen(a_cen), .shift_in(a_in), .shift_out(a_so),
      .set_in(a_set), .readback(a_rb), .conf_out(a_conf),
      .conf_valid(a_val), .frame_err(a_err), .beat_count(a_bc)
   );

   cb_config_loader #(.CONF_WIDTH(200), .LANES(8), .PARITY(1)) dut_b (
      .clk(clk), .rst(rst), .cen(b_cen), .shift_in(b_in), .shift_out(b_so),
      .set_in(b_set), .readback(b_rb), .conf_out(b_conf),
      .conf_valid(b_val), .frame_err(b_err), .beat_count(b_bc)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [255:0] conf;
      bit val;
      bit err;
      int cnt;
      int so;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int NB[2]  = '{3, 26};
   int LW[2]  = '{4, 8};
   int CWD[2] = '{10, 200};

   // beat_m[d][0] is the most recent beat, beat_m[d][NB-1] the oldest (frame MSB).
   int beat_m[2][32];
   int cnt_m[2];
   logic [255:0] conf_m[2];
   bit val_m[2];
   bit err_m[2];

   task automatic chk(string n, logic [255:0] act, logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", n, act, exp);
      end
   endtask

   function automatic logic [255:0] lmask(int w);
      return (256'(1) << w) - 256'(1);
   endfunction

   function automatic logic [255:0] frame_of(int d);
      logic [255:0] f;
      f = '0;
      for (int k = NB[d] - 1; k >= 0; k--)
         f = (f << LW[d]) | 256'(beat_m[d][k]);
      return f;
   endfunction

   function automatic bit xor_low(logic [255:0] f, int n);
      bit p;
      p = 1'b0;
      for (int i = 0; i < n; i++) p ^= f[i];
      return p;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 32; k++) beat_m[d][k] = 0;
         cnt_m[d] = 0;
         conf_m[d] = '0;
         val_m[d] = 1'b0;
         err_m[d] = 1'b0;
      end
   endtask

   task automatic model_step(int d, bit c, bit s, bit r, int din);
      logic [255:0] f;
      if (s) begin
         f = frame_of(d);
         if (cnt_m[d] == NB[d] && xor_low(f, CWD[d] + 1) == 1'b0) begin
            conf_m[d] = f & lmask(CWD[d]);
            val_m[d] = 1'b1;
            err_m[d] = 1'b0;
         end else begin
            err_m[d] = 1'b1;
         end
         cnt_m[d] = 0;
      end else if (r) begin
         f = conf_m[d] | (256'(xor_low(conf_m[d], CWD[d])) << CWD[d]);
         for (int k = 0; k < NB[d]; k++)
            beat_m[d][k] = int'((f >> (k * LW[d])) & lmask(LW[d]));
         cnt_m[d] = NB[d];
      end else if (c) begin
         for (int k = NB[d] - 1; k > 0; k--) beat_m[d][k] = beat_m[d][k-1];
         beat_m[d][0] = din;
         if (cnt_m[d] < NB[d] + 1) cnt_m[d]++;
      end
   endtask

   task automatic idle_inputs();
      a_cen = 0; a_set = 0; a_rb = 0; a_in = '0;
      b_cen = 0; b_set = 0; b_rb = 0; b_in = '0;
   endtask

   task automatic cyc(int d, bit c, bit s, bit r, int din);
      exp_t e;
      @(negedge clk);
      idle_inputs();
      if (d == 0) begin
         a_cen = c; a_set = s; a_rb = r; a_in = din[3:0];
      end else begin
         b_cen = c; b_set = s; b_rb = r; b_in = din[7:0];
      end
      model_step(d, c, s, r, din);
      e.conf = conf_m[d];
      e.val  = val_m[d];
      e.err  = err_m[d];
      e.cnt  = cnt_m[d];
      e.so   = beat_m[d][NB[d] - 1];
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_a_conf"}, 256'(a_conf), '0);
      chk({tag, "_a_val"}, 256'(a_val), '0);
      chk({tag, "_a_err"}, 256'(a_err), '0);
      chk({tag, "_a_bc"}, 256'(a_bc), '0);
      chk({tag, "_a_so"}, 256'(a_so), '0);
      chk({tag, "_b_conf"}, 256'(b_conf), '0);
      chk({tag, "_b_val"}, 256'(b_val), '0);
      chk({tag, "_b_so"}, 256'(b_so), '0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("a_conf", 256'(a_conf), e.conf);
            chk("a_valid", 256'(a_val), 256'(e.val));
            chk("a_err", 256'(a_err), 256'(e.err));
            chk("a_beats", 256'(a_bc), 256'(e.cnt));
            chk("a_shift_out", 256'(a_so), 256'(e.so));
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("b_conf", 256'(b_conf), e.conf);
            chk("b_valid", 256'(b_val), 256'(e.val));
            chk("b_err", 256'(b_err), 256'(e.err));
            chk("b_beats", 256'(b_bc), 256'(e.cnt));
            chk("b_shift_out", 256'(b_so), 256'(e.so));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [255:0] cb, fb;
      int r;
      idle_inputs();
      model_reset();
      rst = 1'b0;
      #12;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // valid load 0x6,0xA,0x5 -> conf 0x2A5
      cyc(0, 1, 0, 0, 4'h6);
      cyc(0, 1, 0, 0, 4'hA);
      cyc(0, 1, 0, 0, 4'h5);
      cyc(0, 0, 1, 0, 0);
      chk("model_load", conf_m[0], 256'h2A5);

      // parity error
      cyc(0, 1, 0, 0, 4'h4);
      cyc(0, 1, 0, 0, 4'hA);
      cyc(0, 1, 0, 0, 4'h5);
      cyc(0, 0, 1, 0, 0);

      // short and over-length frames
      cyc(0, 1, 0, 0, 4'h6);
      cyc(0, 1, 0, 0, 4'hA);
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 4'h6 + i);
      cyc(0, 0, 1, 0, 0);

      // commit wins over a concurrent beat
      cyc(0, 1, 0, 0, 4'h6);
      cyc(0, 1, 0, 0, 4'hA);
      cyc(0, 1, 0, 0, 4'h5);
      cyc(0, 1, 1, 0, 4'hF);

      // readback then immediate re-commit
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 0);
      // readback then shift the frame back out
      cyc(0, 1, 0, 1, 4'h3);
      cyc(0, 1, 0, 0, 4'h6);
      cyc(0, 1, 0, 0, 4'hA);
      cyc(0, 1, 0, 0, 4'h5);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 0);

      // random traffic on the narrow chain
      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 15));
         cyc(0, r < 9, r == 14, r == 15, int'($urandom_range(0, 15)));
      end

      // wide chain: correct-parity frame in exactly 26 beats
      cb = '0;
      for (int i = 0; i < 7; i++) cb[i*32 +: 32] = $urandom;
      cb &= lmask(200);
      fb = cb | (256'(xor_low(cb, 200)) << 200);
      for (int i = 0; i < 26; i++)
         cyc(1, 1, 0, 0, int'((fb >> (8 * (25 - i))) & 256'hFF));
      cyc(1, 0, 1, 0, 0);
      chk("model_wide", conf_m[1], cb);
      for (int i = 0; i < 30; i++)
         cyc(1, 1, 0, 0, int'($urandom_range(0, 255)));
      cyc(1, 0, 1, 0, 0);

      // asynchronous reset mid-frame
      cyc(0, 1, 0, 0, 4'h6);
      cyc(0, 1, 0, 0, 4'hA);
      cyc(0, 1, 0, 0, 4'h5);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 4'h6);
      cyc(0, 1, 0, 0, 4'hA);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk_zero("async_rst");
      model_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
